// File: rtl/motor_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module      : motor_duty_ramp
// Description : Slew-rate limited PWM duty with dead-time direction reversal.
// Revision    : 1.0 - initial release
// ============================================================================
module motor_duty_ramp #(
    parameter int unsigned DEAD_PERIODS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [31:0] period_in,
    input  logic [31:0] target_in,
    input  logic [31:0] step_in,
    output logic [31:0] pwm_period,
    output logic [31:0] pwm_duty,
    output logic        motor_dir,
    output logic        at_target,
    output logic        reversing
);

    localparam logic [31:0] c_dead_load = 32'(DEAD_PERIODS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_dead_cnt;
    logic [31:0] r_mag;
    logic        r_tdir;

    logic [31:0] w_per_eff;
    logic        w_boundary;
    logic [31:0] w_abs;
    logic [31:0] w_mag;
    logic        w_tdir;
    logic [32:0] w_sum;
    logic [31:0] w_up;
    logic [31:0] w_down;
    logic [31:0] w_toward_mag;
    logic [31:0] w_toward_zero;
    logic [31:0] w_first;

    always_comb begin
        w_per_eff  = (pwm_period == 32'd0) ? 32'd1 : pwm_period;
        w_boundary = (r_cnt == w_per_eff - 32'd1);
        w_tdir     = target_in[31];
        // two's-complement negate gives 2^31 for the most negative target
        w_abs      = target_in[31] ? (~target_in + 32'd1) : target_in;
        w_mag      = (w_abs < period_in) ? w_abs : period_in;
        w_sum      = {1'b0, pwm_duty} + {1'b0, step_in};
        w_up       = (w_sum > {1'b0, w_mag}) ? w_mag : w_sum[31:0];
        w_down     = ((pwm_duty - w_mag) <= step_in) ? w_mag : (pwm_duty - step_in);
        if (pwm_duty < w_mag) begin
            w_toward_mag = w_up;
        end else if (pwm_duty > w_mag) begin
            w_toward_mag = w_down;
        end else begin
            w_toward_mag = w_mag;
        end
        w_toward_zero = (pwm_duty > step_in) ? (pwm_duty - step_in) : 32'd0;
        w_first       = (step_in < w_mag) ? step_in : w_mag;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 32'd0;
            r_dead_cnt <= 32'd0;
            r_mag      <= 32'd0;
            r_tdir     <= 1'b0;
            pwm_period <= 32'd0;
            pwm_duty   <= 32'd0;
            motor_dir  <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_cnt      <= 32'd0;
                pwm_period <= period_in;
                r_mag      <= w_mag;
                r_tdir     <= w_tdir;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            // enable low overrides any boundary action in every state
            if (!enable) begin
                r_state  <= ST_IDLE;
                pwm_duty <= 32'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        pwm_duty <= 32'd0;
                        r_state  <= ST_RAMP;
                    end
                    ST_RAMP: begin
                        if (w_boundary) begin
                            if ((w_tdir == motor_dir) || (w_mag == 32'd0)) begin
                                pwm_duty <= w_toward_mag;
                            end else begin
                                pwm_duty <= w_toward_zero;
                                if (w_toward_zero == 32'd0) begin
                                    r_state    <= ST_DEAD;
                                    r_dead_cnt <= c_dead_load;
                                end
                            end
                        end
                    end
                    ST_DEAD: begin
                        pwm_duty <= 32'd0;
                        if (w_boundary) begin
                            if (r_dead_cnt == 32'd0) begin
                                r_state <= ST_RAMP;
                                if ((w_mag != 32'd0) && (w_tdir != motor_dir)) begin
                                    motor_dir <= w_tdir;
                                    pwm_duty  <= w_first;
                                end
                            end else begin
                                r_dead_cnt <= r_dead_cnt - 32'd1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        pwm_duty <= 32'd0;
                    end
                endcase
            end
        end
    end

    assign at_target = (r_state == ST_RAMP) && (pwm_duty == r_mag) &&
                       ((motor_dir == r_tdir) || (r_mag == 32'd0));
    assign reversing = (r_state == ST_DEAD);

endmodule
`default_nettype wire

// File: tb/tb_motor_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_duty_ramp
// Description : Directed self-checking bench for motor_duty_ramp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_duty_ramp;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] period_in;
    logic [31:0] target_in;
    logic [31:0] step_in;
    logic [31:0] pwm_period;
    logic [31:0] pwm_duty;
    logic        motor_dir;
    logic        at_target;
    logic        reversing;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_cnt = 32'd0;
    logic [31:0] m_per = 32'd0;

    motor_duty_ramp #(.DEAD_PERIODS(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .period_in  (period_in),
        .target_in  (target_in),
        .step_in    (step_in),
        .pwm_period (pwm_period),
        .pwm_duty   (pwm_duty),
        .motor_dir  (motor_dir),
        .at_target  (at_target),
        .reversing  (reversing)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] eff(input logic [31:0] p);
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

    // independent period-counter model, used only to locate boundaries
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt <= 32'd0;
            m_per <= 32'd0;
        end else if (m_cnt == eff(m_per) - 32'd1) begin
            m_cnt <= 32'd0;
            m_per <= period_in;
        end else begin
            m_cnt <= m_cnt + 32'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_bnd();
        bit b;
        int n;
        b = 1'b0;
        n = 0;
        do begin
            b = (m_cnt == eff(m_per) - 32'd1);
            @(posedge clk);
            #1;
            n++;
        end while (!b && n < 3000);
        check_eq("bnd_wait", {31'd0, b}, 32'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        enable    = 1'b0;
        period_in = 32'd100;
        target_in = 32'd50;
        step_in   = 32'd20;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_period", pwm_period, 32'd0);
        check_eq("rst_duty", pwm_duty, 32'd0);
        check_eq("rst_dir", {31'd0, motor_dir}, 32'd0);
        check_eq("rst_at_target", {31'd0, at_target}, 32'd0);
        check_eq("rst_reversing", {31'd0, reversing}, 32'd0);

        rstn = 1'b1;
        wait_bnd();
        check_eq("first_bnd_period", pwm_period, 32'd100);
        check_eq("first_bnd_duty", pwm_duty, 32'd0);

        // ramp up 20, 40, 50
        enable = 1'b1;
        wait_bnd();
        check_eq("ramp_20", pwm_duty, 32'd20);
        check_eq("ramp_20_at", {31'd0, at_target}, 32'd0);
        wait_bnd();
        check_eq("ramp_40", pwm_duty, 32'd40);
        wait_bnd();
        check_eq("ramp_50", pwm_duty, 32'd50);
        check_eq("ramp_50_at", {31'd0, at_target}, 32'd1);
        check_eq("ramp_dir", {31'd0, motor_dir}, 32'd0);

        // reversal to -30
        target_in = -32'sd30;
        wait_bnd();
        check_eq("rev_30", pwm_duty, 32'd30);
        check_eq("rev_30_rev", {31'd0, reversing}, 32'd0);
        wait_bnd();
        check_eq("rev_10", pwm_duty, 32'd10);
        wait_bnd();
        check_eq("rev_0", pwm_duty, 32'd0);
        check_eq("rev_dead", {31'd0, reversing}, 32'd1);
        repeat (3) wait_bnd();
        check_eq("dead3_duty", pwm_duty, 32'd0);
        check_eq("dead3_rev", {31'd0, reversing}, 32'd1);
        check_eq("dead3_dir", {31'd0, motor_dir}, 32'd0);
        wait_bnd();
        check_eq("flip_dir", {31'd0, motor_dir}, 32'd1);
        check_eq("flip_duty", pwm_duty, 32'd20);
        check_eq("flip_rev", {31'd0, reversing}, 32'd0);
        wait_bnd();
        check_eq("after_flip", pwm_duty, 32'd30);
        check_eq("after_flip_at", {31'd0, at_target}, 32'd1);

        // safety stop mid-period
        target_in = -32'sd40;
        step_in   = 32'd10;
        wait_bnd();
        check_eq("pre_stop", pwm_duty, 32'd40);
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check_eq("stop_duty", pwm_duty, 32'd0);
        check_eq("stop_at", {31'd0, at_target}, 32'd0);
        check_eq("stop_dir", {31'd0, motor_dir}, 32'd1);
        enable = 1'b1;
        wait_bnd();
        check_eq("reenable", pwm_duty, 32'd10);

        // clamp and saturation with most negative target
        enable = 1'b0;
        @(posedge clk);
        #1;
        enable    = 1'b1;
        target_in = 32'h8000_0000;
        period_in = 32'd1000;
        step_in   = 32'd600;
        wait_bnd();
        check_eq("clamp_600", pwm_duty, 32'd600);
        check_eq("clamp_period", pwm_period, 32'd1000);
        wait_bnd();
        check_eq("clamp_1000", pwm_duty, 32'd1000);
        check_eq("clamp_at", {31'd0, at_target}, 32'd1);
        wait_bnd();
        check_eq("clamp_hold", pwm_duty, 32'd1000);
        period_in = 32'd500;
        wait_bnd();
        check_eq("shrink_duty", pwm_duty, 32'd500);
        check_eq("shrink_period", pwm_period, 32'd500);

        // step 0 freezes duty
        step_in   = 32'd0;
        target_in = -32'sd300;
        wait_bnd();
        check_eq("step0_duty", pwm_duty, 32'd500);
        check_eq("step0_at", {31'd0, at_target}, 32'd0);
        wait_bnd();
        check_eq("step0_hold", pwm_duty, 32'd500);

        // enter DEAD, then reset asynchronously
        step_in   = 32'd500;
        target_in = 32'd300;
        wait_bnd();
        check_eq("dead_entry_duty", pwm_duty, 32'd0);
        check_eq("dead_entry_rev", {31'd0, reversing}, 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("arst_period", pwm_period, 32'd0);
        check_eq("arst_duty", pwm_duty, 32'd0);
        check_eq("arst_dir", {31'd0, motor_dir}, 32'd0);
        check_eq("arst_rev", {31'd0, reversing}, 32'd0);
        period_in = 32'd7;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_bnd();
        check_eq("post_rst_period", pwm_period, 32'd7);
        check_eq("post_rst_duty", pwm_duty, 32'd0);
        wait_bnd();
        check_eq("post_rst_ramp", pwm_duty, 32'd7);
        check_eq("post_rst_dir", {31'd0, motor_dir}, 32'd0);
        check_eq("post_rst_at", {31'd0, at_target}, 32'd1);

        // period 0: boundary every cycle, mag 0
        period_in = 32'd0;
        wait_bnd();
        check_eq("p0_period", pwm_period, 32'd0);
        check_eq("p0_duty", pwm_duty, 32'd0);
        check_eq("p0_at", {31'd0, at_target}, 32'd1);
        wait_bnd();
        check_eq("p0_period2", pwm_period, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_duty_ramp.md
# motor_duty_ramp

Slew-rate limiter and direction sequencer that feeds the PWM generator of each drive motor. Software writes a signed speed target. The block walks the unsigned duty toward the target's magnitude by a fixed step once per PWM period, and enforces a zero-duty dead time before reversing the H-bridge direction. Its `pwm_period`/`pwm_duty` outputs connect directly to the PWM generator inputs, and `motor_dir` drives the bridge direction pin.

## Interface
- `DEAD_PERIODS`, default 4: number of whole PWM periods held at zero duty before a direction flip; legal range ≥1.
- `clk` in 1: single clock, shared with the PWM generator.
- `rstn` in 1: asynchronous, active-low reset.
- `enable` in 1: run control. Low forces zero duty.
- `period_in` in 32: requested PWM period in clk cycles. Value 0 is treated as 1.
- `target_in` in 32: signed target duty. Sign gives direction (≥0 → dir 0, <0 → dir 1); magnitude is the duty in clk cycles.
- `step_in` in 32: unsigned duty change applied per boundary. 0 freezes the duty.
- `pwm_period` out 32: registered period to the PWM generator.
- `pwm_duty` out 32: registered duty magnitude to the PWM generator.
- `motor_dir` out 1: registered bridge direction.
- `at_target` out 1: high when the duty and direction equal the clamped target.
- `reversing` out 1: high while in state DEAD.

## Operation
- **Internal counter `cnt`.**
  - Counts 0..P-1, where P = `pwm_period` (0 treated as 1).
  - `boundary` = (`cnt` == P-1). `cnt` wraps to 0 on `boundary`.
- **Every boundary:**
  - `pwm_period` ← `period_in`.
  - Compute `mag` = min(|`target_in`|, new period). |−2^31| = 2^31 (unsigned, no overflow).
  - Compute `tdir` = `target_in`[31].
- **Duty arithmetic.**
  - Step up: `pwm_duty` ← min(`pwm_duty` + `step_in`, `mag`), computed with a 33-bit sum so no wrap.
  - Step down: `pwm_duty` ← max(`pwm_duty` − `step_in`, `mag`), saturating at 0.
  - Duty never overshoots `mag` in either direction.
- **States: IDLE, RAMP, DEAD.**
- **IDLE.**
  - `pwm_duty` = 0 and `motor_dir` holds its value.
  - On `enable`=1, go to RAMP at the next clock.
- **RAMP, at each boundary:**
  - If `tdir` == `motor_dir`, or `mag` == 0: step `pwm_duty` toward `mag`.
  - If `tdir` != `motor_dir` and `mag` != 0:
    - Step `pwm_duty` toward 0.
    - If the result is 0, enter DEAD at the same edge with `dead_cnt` = `DEAD_PERIODS`−1.
- **DEAD.**
  - `pwm_duty` = 0.
  - At each boundary, `dead_cnt` decrements.
  - At the boundary where `dead_cnt` == 0:
    - `motor_dir` ← `tdir`.
    - `pwm_duty` ← min(`step_in`, `mag`).
    - Return to RAMP.
  - The result is exactly `DEAD_PERIODS` zero-duty periods.
  - If, at that boundary, `mag` == 0 or `tdir` == the old `motor_dir`, return to RAMP without flipping; duty stays 0.
- **`enable`=0 in any state:**
  - At the next clock, `pwm_duty` ← 0 and the state goes to IDLE, regardless of `boundary` (safety stop).
  - `cnt` and `pwm_period` keep updating.
- **`at_target`** = (state == RAMP) && (`pwm_duty` == `mag`) && (`motor_dir` == `tdir` || `mag` == 0).
- **Changes off-boundary.** Changes to `period_in`, `target_in` or `step_in` between boundaries have no effect until the next boundary.

## Timing
- **Reset** (asynchronous, `rstn`=0):
  - `cnt`=0, state IDLE, `dead_cnt`=0.
  - Outputs: `pwm_period`=0, `pwm_duty`=0, `motor_dir`=0, `at_target`=0, `reversing`=0.
- **First boundary after reset.** Occurs on the first clock after `rstn` rises, because period 0 is treated as 1.
- **Latency.**
  - All outputs are registered. Updates land on the clock edge where `boundary`=1, and are visible to the PWM generator at its `cnt`=0.
  - Worst-case latency from a `target_in` change to the first duty change is P cycles.
- **Reset asserted mid-ramp or mid-DEAD.** All outputs go to reset values immediately. No dead time is owed after reset, because duty is already 0.
- **Simultaneous `enable` fall and `boundary`.** `enable` wins: duty goes to 0 and the state goes to IDLE.
- **Period shrink below the current duty.** The clamp to the new `mag` applies at the same boundary.

## Test plan
- **Ramp up:** `period_in`=100, `target_in`=+50, `step_in`=20, `enable`=1 → `pwm_duty` goes 20, 40, 50 on three consecutive boundaries 100 cycles apart. `at_target` rises with 50. `motor_dir`=0.
- **Reversal:** from duty 50 dir 0, set `target_in`=−30 with step 20 and `DEAD_PERIODS`=4 → duty goes 30, 10, 0 (enter DEAD, `reversing`=1), then 4 periods at 0. At the fourth DEAD boundary, `motor_dir`=1 and duty=20. Next boundary duty=30.
- **Clamp and saturation:** `target_in`=−2^31, `period_in`=1000, step 600 → duty goes 600, 1000 and holds. `period_in`→500 → duty=500 at the next boundary.
- **Safety stop:** `enable` dropped mid-period at duty 40 → duty=0 on the next clock, not at a boundary. Re-enable → ramps from 0.
- **Reset mid-DEAD:** `rstn`=0 during DEAD → all outputs 0 asynchronously. After release, the first boundary occurs one clock later and `pwm_period` loads `period_in`.
- **Step 0 and period 0:** `step_in`=0 → duty frozen, `at_target`=0. `period_in`=0 → `boundary` every cycle and `pwm_period`=0.
